// File: rtl/weight_pkg.sv
// Shared definitions for the weight buffer write path: loader FSM states,
// buffer geometry and the byte-count to word-count conversion.
package weight_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL      = 2'd1,
      WAIT_FULL = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam int WB_DEPTH  = 180;
   localparam int WB_DATA_W = 64;
   localparam int WB_TB_W   = 11;

   // Partial trailing words are dropped: only whole 64-bit words are moved.
   function automatic logic [7:0] words_of(input logic [WB_TB_W-1:0] transfer_byte);
      return transfer_byte[WB_TB_W-1:3];
   endfunction

endpackage

// File: rtl/weight_bram_loader.sv
// Feeds the DMA weight stream into NUM_BUF weight BRAM controllers in turn,
// waiting for each buffer to report full before moving to the next one.
module weight_bram_loader
   import weight_pkg::*;
#(
   parameter int NUM_BUF    = 4,
   parameter int DEPTH      = WB_DEPTH,
   parameter int DATA_WIDTH = WB_DATA_W,
   parameter int TIMEOUT    = 15,
   localparam int BUF_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1,
   localparam int TMO_W     = $clog2(TIMEOUT + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [WB_TB_W-1:0]            transfer_byte_i,
   input  logic [DATA_WIDTH-1:0]         s_data_i,
   input  logic                          s_valid_i,
   output logic                          s_ready_o,
   output logic [NUM_BUF*DATA_WIDTH-1:0] wb_din_o,
   output logic [NUM_BUF-1:0]            wb_write_en_o,
   input  logic [NUM_BUF-1:0]            wb_full_n_i,
   output logic [WB_TB_W-1:0]            wb_transfer_byte_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic [BUF_W-1:0]              cur_buf_o
);

   state_t                               state_q, state_d;
   logic [BUF_W-1:0]                     curBuf_q, curBuf_d;
   logic [7:0]                           wordCnt_q, wordCnt_d;
   logic [TMO_W-1:0]                     tmoCnt_q, tmoCnt_d;
   logic [WB_TB_W-1:0]                   xferByte_q, xferByte_d;
   logic                                 err_q, err_d;
   logic [NUM_BUF-1:0][DATA_WIDTH-1:0]   dinHold_q;
   logic [NUM_BUF-1:0][DATA_WIDTH-1:0]   dinOut;
   logic [NUM_BUF-1:0]                   writeEn;
   logic                                 sReady;
   logic                                 fullNCur;
   logic                                 beat;
   logic [7:0]                           startWords;
   logic [7:0]                           loadWords;

   assign fullNCur   = wb_full_n_i[curBuf_q];
   assign beat       = (state_q == FILL) && s_valid_i && fullNCur;
   assign startWords = words_of(transfer_byte_i);
   assign loadWords  = words_of(xferByte_q);

   always_comb begin
      state_d    = state_q;
      curBuf_d   = curBuf_q;
      wordCnt_d  = wordCnt_q;
      tmoCnt_d   = tmoCnt_q;
      xferByte_d = xferByte_q;
      err_d      = 1'b0;
      sReady     = 1'b0;
      writeEn    = '0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if ((startWords == 8'd0) || (startWords > 8'(DEPTH))) begin
                  err_d = 1'b1;
               end else begin
                  xferByte_d = transfer_byte_i;
                  curBuf_d   = '0;
                  wordCnt_d  = '0;
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            sReady = fullNCur;
            if (beat) begin
               writeEn[curBuf_q] = 1'b1;
               if (wordCnt_q == (loadWords - 8'd1)) begin
                  tmoCnt_d = '0;
                  state_d  = WAIT_FULL;
               end else begin
                  wordCnt_d = wordCnt_q + 8'd1;
               end
            end
         end
         WAIT_FULL: begin
            // The buffer must acknowledge the complete transfer before the next lane starts.
            if (!fullNCur) begin
               if (curBuf_q == BUF_W'(NUM_BUF - 1)) begin
                  state_d = DONE;
               end else begin
                  curBuf_d  = curBuf_q + BUF_W'(1);
                  wordCnt_d = '0;
                  state_d   = FILL;
               end
            end else if (tmoCnt_q == TMO_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmoCnt_d = tmoCnt_q + TMO_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The active lane passes the stream straight through; idle lanes show their last word.
   always_comb begin
      dinOut = dinHold_q;
      if (beat) begin
         dinOut[curBuf_q] = s_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         curBuf_q   <= '0;
         wordCnt_q  <= '0;
         tmoCnt_q   <= '0;
         xferByte_q <= '0;
         err_q      <= 1'b0;
         dinHold_q  <= '0;
      end else begin
         state_q    <= state_d;
         curBuf_q   <= curBuf_d;
         wordCnt_q  <= wordCnt_d;
         tmoCnt_q   <= tmoCnt_d;
         xferByte_q <= xferByte_d;
         err_q      <= err_d;
         if (beat) begin
            dinHold_q[curBuf_q] <= s_data_i;
         end
      end
   end

   assign s_ready_o          = sReady;
   assign wb_din_o           = dinOut;
   assign wb_write_en_o      = writeEn;
   assign wb_transfer_byte_o = xferByte_q;
   assign busy_o             = (state_q != IDLE);
   assign done_o             = (state_q == DONE);
   assign err_o              = err_q;
   assign cur_buf_o          = curBuf_q;

endmodule

// File: tb/tb_weight_bram_loader.sv
// Self-checking bench for weight_bram_loader: a table of whole-load scenarios
// against a simple buffer/source model, plus reset corner-case sequences.
module tb_weight_bram_loader;

   localparam int NB = 4;

   logic           clk;
   logic           rst;
   logic           start;
   logic [10:0]    transferByte;
   logic [63:0]    sData;
   logic           sValid;
   logic           sReady;
   logic [NB*64-1:0] wbDin;
   logic [NB-1:0]  wbWriteEn;
   logic [NB-1:0]  wbFullN;
   logic [10:0]    wbTransferByte;
   logic           busy;
   logic           done;
   logic           err;
   logic [1:0]     curBuf;

   typedef struct {
      logic [10:0] tb;
      int          words;
      int          srcMode;
      int          stuck;
      int          fBuf;
      int          fAt;
      int          midStart;
      bit          legal;
      int          expDone;
      int          expErr;
      int          expCyc;
      int          expWr;
      int          expWr3;
      logic [10:0] expTbOut;
   } vec_t;

   vec_t        vecs[9];
   int          nChecks = 0;
   int          nFails  = 0;
   int          wrCnt[NB];
   int          modelWords = 0;
   int          stuckBuf = -1;
   int          forceBuf = -1;
   int          forceAt = 0;
   int          forceLeft = 0;
   bit          forceArmed = 0;
   int          srcIdx = 0;
   int          srcMode = 0;
   int          doneCnt = 0;
   int          errCnt = 0;
   int          doneCyc = -1;
   int          errCyc = -1;
   int          vio = 0;
   int          cyc = 0;
   int          startCyc = 0;
   logic [10:0] expTb = '0;
   bit          tbCheckEn = 0;
   logic        busyAt1;

   weight_bram_loader dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .start_i            (start),
      .transfer_byte_i    (transferByte),
      .s_data_i           (sData),
      .s_valid_i          (sValid),
      .s_ready_o          (sReady),
      .wb_din_o           (wbDin),
      .wb_write_en_o      (wbWriteEn),
      .wb_full_n_i        (wbFullN),
      .wb_transfer_byte_o (wbTransferByte),
      .busy_o             (busy),
      .done_o             (done),
      .err_o              (err),
      .cur_buf_o          (curBuf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [63:0] pattern(input int i);
      return 64'hC0DE000000000000 + 64'(i);
   endfunction

   // Buffer model: full_n drops right after the buffer has taken its last word.
   always @(posedge clk) begin
      #1;
      if (forceArmed && forceBuf >= 0 && wrCnt[forceBuf] >= forceAt) begin
         forceArmed = 0;
         forceLeft  = 10;
      end
      for (int b = 0; b < NB; b++) begin
         wbFullN[b] = !((modelWords > 0) && (wrCnt[b] >= modelWords) && (b != stuckBuf))
                      && !((forceLeft > 0) && (b == forceBuf));
      end
      if (forceLeft > 0) forceLeft = forceLeft - 1;
   end

   always @(posedge clk) begin
      #1;
      case (srcMode)
         1:       sValid = 1'b1;
         2:       sValid = ($urandom_range(0, 3) != 0);
         default: sValid = 1'b0;
      endcase
      sData = pattern(srcIdx);
   end

   always @(negedge clk) begin
      if ($countones(wbWriteEn) > 1) vio++;
      for (int b = 0; b < NB; b++) begin
         if (wbWriteEn[b]) begin
            if (!wbFullN[b]) vio++;
            if (!(sValid && sReady)) vio++;
            if (wbDin[b*64 +: 64] !== pattern(b*modelWords + wrCnt[b])) vio++;
            wrCnt[b]++;
         end
      end
      if (sValid && sReady) srcIdx++;
      if (done) begin
         doneCnt++;
         if (doneCyc < 0) doneCyc = cyc - startCyc;
      end
      if (err) begin
         errCnt++;
         if (errCyc < 0) errCyc = cyc - startCyc;
      end
      if (busy && tbCheckEn && (wbTransferByte !== expTb)) vio++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic resetModel(input int words, input int stuck, input int fBuf, input int fAt);
      for (int b = 0; b < NB; b++) wrCnt[b] = 0;
      modelWords = words;
      stuckBuf   = stuck;
      forceBuf   = fBuf;
      forceAt    = fAt;
      forceArmed = (fBuf >= 0);
      forceLeft  = 0;
      srcIdx     = 0;
      doneCnt    = 0;
      errCnt     = 0;
      doneCyc    = -1;
      errCyc     = -1;
      vio        = 0;
   endtask

   task automatic checkResetOutputs(input string pfx);
      check({pfx, ".s_ready"}, 64'(sReady), 64'd0);
      check({pfx, ".write_en"}, 64'(wbWriteEn), 64'd0);
      check({pfx, ".din_or"}, 64'(|wbDin), 64'd0);
      check({pfx, ".xfer_byte"}, 64'(wbTransferByte), 64'd0);
      check({pfx, ".busy"}, 64'(busy), 64'd0);
      check({pfx, ".done"}, 64'(done), 64'd0);
      check({pfx, ".err"}, 64'(err), 64'd0);
      check({pfx, ".cur_buf"}, 64'(curBuf), 64'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk); #1;
      resetModel(v.words, v.stuck, v.fBuf, v.fAt);
      srcMode      = v.srcMode;
      expTb        = v.tb;
      tbCheckEn    = 0;
      transferByte = v.tb;
      start        = 1'b1;
      startCyc     = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
      tbCheckEn = v.legal;
      @(negedge clk);
      busyAt1 = busy;
      for (int i = 0; i < 3000 && (doneCnt + errCnt) == 0; i++) begin
         @(posedge clk); #1;
         if (v.midStart > 0 && (cyc - startCyc) == v.midStart) begin
            start        = 1'b1;
            transferByte = 11'd16;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      srcMode   = 0;
      tbCheckEn = 0;
      @(negedge clk);
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      check({p, ".busy_at_1"}, 64'(busyAt1), 64'(v.legal));
      check({p, ".done_count"}, 64'(doneCnt), 64'(v.expDone));
      check({p, ".err_count"}, 64'(errCnt), 64'(v.expErr));
      if (v.expCyc > 0) begin
         if (v.expDone > 0) check({p, ".done_cycle"}, 64'(doneCyc), 64'(v.expCyc));
         else               check({p, ".err_cycle"}, 64'(errCyc), 64'(v.expCyc));
      end
      for (int b = 0; b < NB - 1; b++)
         check($sformatf("%s.writes_buf%0d", p, b), 64'(wrCnt[b]), 64'(v.expWr));
      check({p, ".writes_buf3"}, 64'(wrCnt[3]), 64'(v.expWr3));
      check({p, ".protocol_violations"}, 64'(vio), 64'd0);
      check({p, ".busy_end"}, 64'(busy), 64'd0);
      check({p, ".xfer_byte_end"}, 64'(wbTransferByte), 64'(v.expTbOut));
   endtask

   task automatic resetMidLoad();
      int sum;
      @(posedge clk); #1;
      resetModel(180, -1, -1, 0);
      srcMode      = 1;
      transferByte = 11'd1440;
      start        = 1'b1;
      startCyc     = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 400 && wrCnt[0] < 50; i++) begin
         @(posedge clk); #1;
      end
      check("rstmid.reached_50", 64'(wrCnt[0] >= 50), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("rstmid");
      sum = wrCnt[0];
      repeat (3) @(negedge clk);
      check("rstmid.no_more_writes", 64'(wrCnt[0] - sum + wrCnt[1]), 64'd0);
      @(posedge clk); #1;
      srcMode = 0;
   endtask

   task automatic startWithReset();
      int sum;
      @(posedge clk); #1;
      resetModel(180, -1, -1, 0);
      srcMode      = 1;
      transferByte = 11'd1440;
      start        = 1'b1;
      rst          = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("startrst.busy", 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      sum = wrCnt[0] + wrCnt[1] + wrCnt[2] + wrCnt[3];
      check("startrst.writes", 64'(sum), 64'd0);
      check("startrst.s_ready", 64'(sReady), 64'd0);
      check("startrst.xfer_byte", 64'(wbTransferByte), 64'd0);
      @(posedge clk); #1;
      srcMode = 0;
   endtask

   initial begin
      vecs[0] = '{11'd1440, 180, 1, -1, -1,  0,   0, 1'b1, 1, 0, 725, 180, 180, 11'd1440};
      vecs[1] = '{11'd0,      0, 1, -1, -1,  0,   0, 1'b0, 0, 1,   1,   0,   0, 11'd1440};
      vecs[2] = '{11'd1448,   0, 1, -1, -1,  0,   0, 1'b0, 0, 1,   1,   0,   0, 11'd1440};
      vecs[3] = '{11'd800,  100, 2, -1,  1, 50,   0, 1'b1, 1, 0,   0, 100, 100, 11'd800};
      vecs[4] = '{11'd1447, 180, 1, -1, -1,  0, 300, 1'b1, 1, 0, 725, 180, 180, 11'd1447};
      vecs[5] = '{11'd7,      0, 1, -1, -1,  0,   0, 1'b0, 0, 1,   1,   0,   0, 11'd1447};
      vecs[6] = '{11'd8,      1, 1, -1, -1,  0,   0, 1'b1, 1, 0,   9,   1,   1, 11'd8};
      vecs[7] = '{11'd1440, 180, 1,  2, -1,  0,   0, 1'b1, 0, 1, 558, 180,   0, 11'd1440};
      vecs[8] = '{11'd800,  100, 1, -1, -1,  0,   0, 1'b1, 1, 0, 405, 100, 100, 11'd800};

      rst          = 1'b1;
      start        = 1'b0;
      transferByte = '0;
      sValid       = 1'b0;
      sData        = '0;
      wbFullN      = '1;
      for (int b = 0; b < NB; b++) wrCnt[b] = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("reset");

      for (int i = 0; i < 9; i++) begin
         if (i == 8) resetMidLoad();
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end

      startWithReset();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
